cpu_sequencer: RTL and testbench

- Control sequencer and fetch stage that sits directly upstream of the instruction decoder.
- Owns the fetch/exec1/exec2/halt state register, the program counter, the instruction register (IR) and the extension-word operand register.
- Drives `state` and `instruction` into the decoder; consumes the decoder's `sm_extra`, `stop`, `ir_en`, `pc_sload` and `pc_cnt_en` back.

---
 rtl/cpu_sequencer_if.sv | 41 ++++
 rtl/cpu_sequencer.sv | 112 +++++++++++
 tb/tb_cpu_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer bus: decoder feedback, imem data/address, status.
// master = sequencer side, slave = decoder/imem side. Macro: CPU_SEQUENCER_INSTR_COUNT_EN.
interface cpu_sequencer_if #(
  parameter int ADDR_W = 10
);
  logic [15:0]       instr_q;
  logic              sm_extra;
  logic              ir_en;
  logic              pc_sload;
  logic              pc_cnt_en;
  logic [ADDR_W-1:0] jump_target;
  logic              stop;
  logic              stall;
  logic [1:0]        state;
  logic [15:0]       instruction;
  logic [15:0]       operand;
  logic [ADDR_W-1:0] pc;
  logic              instr_done;
  logic              halted;
`ifdef CPU_SEQUENCER_INSTR_COUNT_EN
  logic [31:0]       instr_count;
`endif

  modport master (
    input  instr_q, sm_extra, ir_en, pc_sload, pc_cnt_en,
    input  jump_target, stop, stall,
    output state, instruction, operand, pc, instr_done, halted
`ifdef CPU_SEQUENCER_INSTR_COUNT_EN
    , output instr_count
`endif
  );

  modport slave (
    output instr_q, sm_extra, ir_en, pc_sload, pc_cnt_en,
    output jump_target, stop, stall,
    input  state, instruction, operand, pc, instr_done, halted
`ifdef CPU_SEQUENCER_INSTR_COUNT_EN
    , input instr_count
`endif
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Fetch/exec sequencer: state, PC, IR, operand; ports clk, reset, bus (master).
// All outputs registered. Macro CPU_SEQUENCER_INSTR_COUNT_EN adds instr_count.
module cpu_sequencer #(
  parameter int ADDR_W   = 10,
  parameter int RESET_PC = 0
) (
  input logic              clk,
  input logic              reset,
  cpu_sequencer_if.master  bus
);
  typedef enum logic [1:0] {
    FETCH = 2'b00,
    EXEC2 = 2'b01,
    EXEC1 = 2'b10,
    HALT  = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [15:0]       op_q, op_d;
  logic              done_q, done_d;
  logic              halt_q;
  logic              pc_upd;

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    op_d    = op_q;
    done_d  = 1'b0;
    pc_upd  = 1'b0;
    unique case (state_q)
      FETCH: begin
        state_d = EXEC1;
        ir_d    = bus.instr_q;
        pc_upd  = 1'b1;
      end
      EXEC1: begin
        if (!bus.stall) begin
          state_d = bus.sm_extra ? EXEC2 : FETCH;
          done_d  = !bus.sm_extra;
          pc_upd  = 1'b1;
          if (bus.ir_en)
            op_d = bus.instr_q;
        end
      end
      EXEC2: begin
        state_d = FETCH;
        done_d  = 1'b1;
        pc_upd  = 1'b1;
      end
      HALT: state_d = HALT;
    endcase
    // stop freezes the datapath and beats stall/sm_extra
    if (bus.stop && state_q != HALT) begin
      state_d = HALT;
      ir_d    = ir_q;
      op_d    = op_q;
      done_d  = 1'b0;
      pc_upd  = 1'b0;
    end
  end

  always_comb begin
    pc_d = pc_q;
    if (pc_upd) begin
      if (bus.pc_sload)
        pc_d = bus.jump_target;
      else if (bus.pc_cnt_en)
        pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= ADDR_W'(RESET_PC);
      ir_q    <= 16'h0000;
      op_q    <= 16'h0000;
      done_q  <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      op_q    <= op_d;
      done_q  <= done_d;
      halt_q  <= (state_d == HALT);
    end
  end

  assign bus.state       = state_q;
  assign bus.instruction = ir_q;
  assign bus.operand     = op_q;
  assign bus.pc          = pc_q;
  assign bus.instr_done  = done_q;
  assign bus.halted      = halt_q;

`ifdef CPU_SEQUENCER_INSTR_COUNT_EN
  logic [31:0] cnt_q;

  // counts in step with instr_done rising; never in HALT
  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= 32'd0;
    else if (done_d)
      cnt_q <= cnt_q + 32'd1;
  end

  assign bus.instr_count = cnt_q;
`endif
endmodule

// File: tb/tb_cpu_sequencer.sv
// Testbench for cpu_sequencer: directed vector table plus hand sequences.
// Prints CHECKS/ERRORS summary.
module tb_cpu_sequencer;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  cpu_sequencer_if #(.ADDR_W(10)) bus ();

  cpu_sequencer #(.ADDR_W(10), .RESET_PC(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic        stop;
    logic        sm_extra;
    logic        ir_en;
    logic        sload;
    logic        cnt;
    logic [15:0] iq;
    logic [9:0]  jt;
    logic [1:0]  e_state;
    logic [9:0]  e_pc;
    logic [15:0] e_ir;
    logic [15:0] e_op;
    logic        e_done;
    logic        e_halt;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, stall, stop, sme, ire, sl, cn,
                     input logic [15:0] iq, input logic [9:0] jt,
                     input logic [1:0] es, input logic [9:0] ep,
                     input logic [15:0] eir, eop,
                     input logic ed, eh);
    vec_t v;
    v.rst = rst; v.stall = stall; v.stop = stop;
    v.sm_extra = sme; v.ir_en = ire; v.sload = sl; v.cnt = cn;
    v.iq = iq; v.jt = jt;
    v.e_state = es; v.e_pc = ep; v.e_ir = eir; v.e_op = eop;
    v.e_done = ed; v.e_halt = eh;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, stall, stop, sme, ire, sl, cn,
                       input logic [15:0] iq, input logic [9:0] jt);
    reset         = rst;
    bus.stall     = stall;
    bus.stop      = stop;
    bus.sm_extra  = sme;
    bus.ir_en     = ire;
    bus.pc_sload  = sl;
    bus.pc_cnt_en = cn;
    bus.instr_q   = iq;
    bus.jump_target = jt;
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic two);
    drive(0, 0, 0, 0, 0, 0, 1, 16'h1000, 10'h0);
    drive(0, 0, 0, two, two, 0, 1, 16'h2000, 10'h0);
    if (two)
      drive(0, 0, 0, 0, 0, 0, 0, 16'h0, 10'h0);
  endtask

  initial begin
    //  rst stl stp sme ire sl cn iq        jt      st     pc      ir        op        d  h
    add(1, 0, 0, 0, 0, 0, 0, 16'h0000, 10'h0,   2'b00, 10'h0,  16'h0000, 16'h0000, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 16'h4123, 10'h0,   2'b10, 10'h1,  16'h4123, 16'h0000, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 16'h9999, 10'h0,   2'b00, 10'h1,  16'h4123, 16'h0000, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 16'h8001, 10'h0,   2'b10, 10'h2,  16'h8001, 16'h0000, 0, 0);
    add(0, 0, 0, 1, 1, 0, 1, 16'hBEEF, 10'h0,   2'b01, 10'h3,  16'h8001, 16'hBEEF, 0, 0);
    add(0, 1, 0, 0, 1, 0, 0, 16'h1234, 10'h0,   2'b00, 10'h3,  16'h8001, 16'hBEEF, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 16'h1111, 10'h0,   2'b10, 10'h4,  16'h1111, 16'hBEEF, 0, 0);
    for (int i = 0; i < 3; i++)
      add(0, 1, 0, 0, 1, 0, 1, 16'h2222, 10'h0, 2'b10, 10'h4,  16'h1111, 16'hBEEF, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 16'h0000, 10'h155, 2'b00, 10'h155, 16'h1111, 16'hBEEF, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 16'h3333, 10'h3FF, 2'b10, 10'h3FF, 16'h3333, 16'hBEEF, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 16'h0000, 10'h0,   2'b00, 10'h0,  16'h3333, 16'hBEEF, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 16'h4444, 10'h0,   2'b10, 10'h1,  16'h4444, 16'hBEEF, 0, 0);
    add(0, 1, 1, 1, 1, 0, 1, 16'h5555, 10'h0,   2'b11, 10'h1,  16'h4444, 16'hBEEF, 0, 1);
    for (int i = 0; i < 10; i++)
      add(0, 0, i[0], 1, 1, 1, 1, 16'h6666, 10'h2AA,
          2'b11, 10'h1, 16'h4444, 16'hBEEF, 0, 1);
    add(1, 0, 0, 0, 0, 0, 1, 16'h0000, 10'h0,   2'b00, 10'h0,  16'h0000, 16'h0000, 0, 0);
    add(0, 0, 1, 0, 0, 0, 1, 16'h7777, 10'h0,   2'b11, 10'h0,  16'h0000, 16'h0000, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 16'h0000, 10'h0,   2'b00, 10'h0,  16'h0000, 16'h0000, 0, 0);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      drive(v.rst, v.stall, v.stop, v.sm_extra, v.ir_en, v.sload, v.cnt,
            v.iq, v.jt);
      check($sformatf("v%0d state", i), 32'(bus.state), 32'(v.e_state));
      check($sformatf("v%0d pc", i), 32'(bus.pc), 32'(v.e_pc));
      check($sformatf("v%0d ir", i), 32'(bus.instruction), 32'(v.e_ir));
      check($sformatf("v%0d op", i), 32'(bus.operand), 32'(v.e_op));
      check($sformatf("v%0d done", i), 32'(bus.instr_done), 32'(v.e_done));
      check($sformatf("v%0d halt", i), 32'(bus.halted), 32'(v.e_halt));
    end

    // reset taken mid-instruction (in EXEC2)
    drive(0, 0, 0, 0, 0, 0, 1, 16'hAAAA, 10'h0);
    drive(0, 0, 0, 1, 1, 0, 1, 16'hCCCC, 10'h0);
    check("mid exec2 state", 32'(bus.state), 32'h1);
    drive(1, 0, 0, 0, 0, 0, 1, 16'h0, 10'h0);
    check("mid rst state", 32'(bus.state), 32'h0);
    check("mid rst pc", 32'(bus.pc), 32'h0);
    check("mid rst op", 32'(bus.operand), 32'h0);
    check("mid rst done", 32'(bus.instr_done), 32'h0);
    drive(0, 0, 0, 0, 0, 0, 0, 16'h0, 10'h0);
    check("post rst done", 32'(bus.instr_done), 32'h0);
    drive(1, 0, 0, 0, 0, 0, 0, 16'h0, 10'h0);

`ifdef CPU_SEQUENCER_INSTR_COUNT_EN
    check("cnt reset", bus.instr_count, 32'd0);
    for (int i = 0; i < 5; i++)
      run_instr(1'b0);
    run_instr(1'b1);
    run_instr(1'b1);
    check("cnt seven", bus.instr_count, 32'd7);
    drive(0, 0, 1, 0, 0, 0, 1, 16'h0, 10'h0);
    check("cnt halted", 32'(bus.halted), 32'd1);
    for (int i = 0; i < 5; i++)
      drive(0, 0, 0, 0, 0, 0, 1, 16'h0, 10'h0);
    check("cnt hold", bus.instr_count, 32'd7);
    drive(1, 0, 0, 0, 0, 0, 0, 16'h0, 10'h0);
    check("cnt clear", bus.instr_count, 32'd0);
`else
    run_instr(1'b1);
    check("two word pc", 32'(bus.pc), 32'd2);
    check("two word op", 32'(bus.operand), 32'h2000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
